seg_scan_ctrl: RTL and testbench

// Upstream feeder for seg_decoder on the ball-game scoreboard. Captures two binary

---
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: captures two binary scores, converts each to BCD tens/ones by
// repeated subtraction of ten, and time-multiplexes the four digits onto the
// shared num bus with active-low anode enables lagging num by one clock.
module seg_scan_ctrl #(
    parameter int SCAN_DIV   = 50000,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] val_a,
    input  logic [6:0] val_b,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] num,
    output logic [3:0] an
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV_A = 2'd1;
    localparam logic [1:0] CONV_B = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    logic [1:0]    state;
    logic [6:0]    rem_a, rem_b;
    logic [3:0]    tens_a, ones_a, tens_b, ones_b;
    logic          ovf_a, ovf_b;

    logic [3:0]    disp_tens_a, disp_ones_a, disp_tens_b, disp_ones_b;
    logic          disp_ovf_a, disp_ovf_b;

    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [1:0]    sel_next;
    logic          tc;
    logic [3:0]    num_next;
    logic          blank;

    // Conversion FSM: capture, subtract tens out of A then B, then commit all
    // digits to the display registers in one edge so the scan never sees a
    // half-converted score.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rem_a       <= '0;
            rem_b       <= '0;
            tens_a      <= '0;
            ones_a      <= '0;
            tens_b      <= '0;
            ones_b      <= '0;
            ovf_a       <= 1'b0;
            ovf_b       <= 1'b0;
            disp_tens_a <= '0;
            disp_ones_a <= '0;
            disp_tens_b <= '0;
            disp_ones_b <= '0;
            disp_ovf_a  <= 1'b0;
            disp_ovf_b  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        ovf_a  <= (val_a > 7'd99);
                        ovf_b  <= (val_b > 7'd99);
                        rem_a  <= (val_a > 7'd99) ? 7'd0 : val_a;
                        rem_b  <= (val_b > 7'd99) ? 7'd0 : val_b;
                        tens_a <= '0;
                        tens_b <= '0;
                        busy   <= 1'b1;
                        state  <= CONV_A;
                    end
                end
                CONV_A: begin
                    if (rem_a >= 7'd10) begin
                        rem_a  <= rem_a - 7'd10;
                        tens_a <= tens_a + 4'd1;
                    end else begin
                        ones_a <= rem_a[3:0];
                        state  <= CONV_B;
                    end
                end
                CONV_B: begin
                    if (rem_b >= 7'd10) begin
                        rem_b  <= rem_b - 7'd10;
                        tens_b <= tens_b + 4'd1;
                    end else begin
                        ones_b <= rem_b[3:0];
                        state  <= COMMIT;
                    end
                end
                default: begin
                    disp_tens_a <= tens_a;
                    disp_ones_a <= ones_a;
                    disp_tens_b <= tens_b;
                    disp_ones_b <= ones_b;
                    disp_ovf_a  <= ovf_a;
                    disp_ovf_b  <= ovf_b;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Slot selection: num follows the slot that sel is about to hold, and the
    // blank decision looks at the slot sel holds now, which feeds the lagging anodes.
    always_comb begin
        tc       = (cnt == CW'(SCAN_DIV - 1));
        sel_next = tc ? (sel + 2'd1) : sel;
        case (sel_next)
            2'd0:    num_next = disp_ovf_b ? 4'hA : disp_ones_b;
            2'd1:    num_next = disp_ovf_b ? 4'hA : disp_tens_b;
            2'd2:    num_next = disp_ovf_a ? 4'hA : disp_ones_a;
            default: num_next = disp_ovf_a ? 4'hA : disp_tens_a;
        endcase
        case (sel)
            2'd1:    blank = BLANK_LEAD && !disp_ovf_b && (disp_tens_b == 4'd0);
            2'd3:    blank = BLANK_LEAD && !disp_ovf_a && (disp_tens_a == 4'd0);
            default: blank = 1'b0;
        endcase
    end

    // Scan prescaler, slot select, digit bus and anode drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sel <= 2'd0;
            num <= 4'h0;
            an  <= 4'b1111;
        end else begin
            cnt <= tc ? '0 : (cnt + CW'(1));
            sel <= sel_next;
            num <= num_next;
            an  <= blank ? 4'b1111 : ~(4'b0001 << sel);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4; one blanking instance and
// one non-blanking instance share all inputs.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] val_a, val_b;
    logic       load;
    logic       busy, done;
    logic [3:0] num, an;
    logic       busy0, done0;
    logic [3:0] num0, an0;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_num [4];
    logic [3:0] exp_an  [4];
    logic [3:0] exp_an0 [4];

    // Reference scan position, derived from the scan timing alone.
    int         ref_cnt;
    logic [1:0] ref_sel, ref_prev;

    seg_scan_ctrl #(.SCAN_DIV(4), .BLANK_LEAD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .val_a(val_a), .val_b(val_b), .load(load),
        .busy(busy), .done(done), .num(num), .an(an)
    );

    seg_scan_ctrl #(.SCAN_DIV(4), .BLANK_LEAD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .val_a(val_a), .val_b(val_b), .load(load),
        .busy(busy0), .done(done0), .num(num0), .an(an0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tracks which slot should be showing at every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= 0;
            ref_sel  <= 2'd0;
            ref_prev <= 2'd0;
        end else begin
            ref_prev <= ref_sel;
            if (ref_cnt == 3) begin
                ref_cnt <= 0;
                ref_sel <= ref_sel + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 1;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(input logic [6:0] a, input logic [6:0] b);
        val_a = a;
        val_b = b;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
    endtask

    // Waits for busy to drop; reports busy cycles, done pulses seen and timeout.
    task automatic wait_idle(output int cycles, output int dones, output bit timeout);
        cycles  = 0;
        dones   = 0;
        timeout = 1'b0;
        while (busy === 1'b1 && cycles < 60) begin
            cycles++;
            if (done === 1'b1) dones++;
            tick(1);
        end
        if (busy !== 1'b0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        val_a = '0;
        val_b = '0;
        tick(3);
        total++; if (num !== 4'h0)    begin bad++; $display("[TB] FAIL reset_num got=%h want=0", num); end
        total++; if (an !== 4'b1111)  begin bad++; $display("[TB] FAIL reset_an got=%b want=1111", an); end
        total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)   begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        rst_n = 1'b1;
        tick(1);
        total++; if (an !== 4'b1110)  begin bad++; $display("[TB] FAIL reset_first_an got=%b want=1110", an); end
        total++; if (num !== 4'h0)    begin bad++; $display("[TB] FAIL reset_first_num got=%h want=0", num); end
        exp_num = '{4'h0, 4'h0, 4'h0, 4'h0};
        exp_an  = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
        exp_an0 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 16; i++) begin
            tick(1);
            total++; if (num !== exp_num[ref_sel]) begin bad++; $display("[TB] FAIL reset_scan_num slot=%0d got=%h want=%h", ref_sel, num, exp_num[ref_sel]); end
            total++; if (an !== exp_an[ref_prev])  begin bad++; $display("[TB] FAIL reset_scan_an slot=%0d got=%b want=%b", ref_prev, an, exp_an[ref_prev]); end
            total++; if (an0 !== exp_an0[ref_prev]) begin bad++; $display("[TB] FAIL reset_scan_an0 slot=%0d got=%b want=%b", ref_prev, an0, exp_an0[ref_prev]); end
        end
    endtask

    task automatic test_convert();
        int cyc, dn;
        bit to;
        start_load(7'd57, 7'd3);
        wait_idle(cyc, dn, to);
        total++; if (to)            begin bad++; $display("[TB] FAIL conv_timeout got=busy_stuck want=idle"); end
        total++; if (cyc != 8)      begin bad++; $display("[TB] FAIL conv_busy_cycles got=%0d want=8", cyc); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL conv_done got=%b want=1", done); end
        tick(1);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL conv_done_width got=%b want=0", done); end
        total++; if (dn != 0)       begin bad++; $display("[TB] FAIL conv_done_early got=%0d want=0", dn); end
        tick(4);
        exp_num = '{4'd3, 4'd0, 4'd7, 4'd5};
        exp_an  = '{4'b1110, 4'b1111, 4'b1011, 4'b0111};
        for (int i = 0; i < 16; i++) begin
            tick(1);
            total++; if (num !== exp_num[ref_sel]) begin bad++; $display("[TB] FAIL conv_scan_num slot=%0d got=%h want=%h", ref_sel, num, exp_num[ref_sel]); end
            total++; if (an !== exp_an[ref_prev])  begin bad++; $display("[TB] FAIL conv_scan_an slot=%0d got=%b want=%b", ref_prev, an, exp_an[ref_prev]); end
        end
    endtask

    task automatic test_overflow();
        int cyc, dn;
        bit to;
        start_load(7'd120, 7'd99);
        wait_idle(cyc, dn, to);
        total++; if (to || cyc != 12) begin bad++; $display("[TB] FAIL ovf_busy_cycles got=%0d want=12", cyc); end
        tick(4);
        exp_num = '{4'd9, 4'd9, 4'hA, 4'hA};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 16; i++) begin
            tick(1);
            total++; if (num !== exp_num[ref_sel]) begin bad++; $display("[TB] FAIL ovf_scan_num slot=%0d got=%h want=%h", ref_sel, num, exp_num[ref_sel]); end
            total++; if (an !== exp_an[ref_prev])  begin bad++; $display("[TB] FAIL ovf_scan_an slot=%0d got=%b want=%b", ref_prev, an, exp_an[ref_prev]); end
        end
    endtask

    task automatic test_load_while_busy();
        int cyc, dn;
        bit to;
        start_load(7'd42, 7'd17);
        tick(1);
        val_a = 7'd88;
        val_b = 7'd66;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
        wait_idle(cyc, dn, to);
        total++; if (to || cyc != 6) begin bad++; $display("[TB] FAIL busy_load_cycles got=%0d want=6", cyc); end
        tick(1);
        total++; if (busy !== 1'b0)  begin bad++; $display("[TB] FAIL busy_load_queued got=%b want=0", busy); end
        tick(4);
        exp_num = '{4'd7, 4'd1, 4'd2, 4'd4};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 16; i++) begin
            tick(1);
            total++; if (num !== exp_num[ref_sel]) begin bad++; $display("[TB] FAIL busy_scan_num slot=%0d got=%h want=%h", ref_sel, num, exp_num[ref_sel]); end
            total++; if (an !== exp_an[ref_prev])  begin bad++; $display("[TB] FAIL busy_scan_an slot=%0d got=%b want=%b", ref_prev, an, exp_an[ref_prev]); end
        end
    endtask

    task automatic test_no_blank();
        int cyc, dn;
        bit to;
        start_load(7'd0, 7'd4);
        wait_idle(cyc, dn, to);
        total++; if (to || cyc != 3) begin bad++; $display("[TB] FAIL noblank_cycles got=%0d want=3", cyc); end
        tick(4);
        exp_num = '{4'd4, 4'd0, 4'd0, 4'd0};
        exp_an  = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
        exp_an0 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 16; i++) begin
            tick(1);
            total++; if (num0 !== exp_num[ref_sel]) begin bad++; $display("[TB] FAIL noblank_num0 slot=%0d got=%h want=%h", ref_sel, num0, exp_num[ref_sel]); end
            total++; if (an0 !== exp_an0[ref_prev]) begin bad++; $display("[TB] FAIL noblank_an0 slot=%0d got=%b want=%b", ref_prev, an0, exp_an0[ref_prev]); end
            total++; if (an !== exp_an[ref_prev])   begin bad++; $display("[TB] FAIL noblank_an slot=%0d got=%b want=%b", ref_prev, an, exp_an[ref_prev]); end
        end
    endtask

    task automatic test_reset_mid_conv();
        int cyc, dn;
        bit to;
        int seen;
        start_load(7'd15, 7'd37);
        tick(2);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0)  begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
        total++; if (an !== 4'b1111) begin bad++; $display("[TB] FAIL midrst_an got=%b want=1111", an); end
        total++; if (num !== 4'h0)   begin bad++; $display("[TB] FAIL midrst_num got=%h want=0", num); end
        tick(2);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL midrst_activity got=%0d want=0", seen); end
        exp_num = '{4'h0, 4'h0, 4'h0, 4'h0};
        exp_an  = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
        for (int i = 0; i < 16; i++) begin
            tick(1);
            total++; if (num !== exp_num[ref_sel]) begin bad++; $display("[TB] FAIL midrst_scan_num slot=%0d got=%h want=%h", ref_sel, num, exp_num[ref_sel]); end
            total++; if (an !== exp_an[ref_prev])  begin bad++; $display("[TB] FAIL midrst_scan_an slot=%0d got=%b want=%b", ref_prev, an, exp_an[ref_prev]); end
        end
        start_load(7'd64, 7'd28);
        wait_idle(cyc, dn, to);
        total++; if (to || cyc != 11) begin bad++; $display("[TB] FAIL midrst_reload_cycles got=%0d want=11", cyc); end
        tick(4);
        exp_num = '{4'd8, 4'd2, 4'd4, 4'd6};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 16; i++) begin
            tick(1);
            total++; if (num !== exp_num[ref_sel]) begin bad++; $display("[TB] FAIL reload_scan_num slot=%0d got=%h want=%h", ref_sel, num, exp_num[ref_sel]); end
            total++; if (an !== exp_an[ref_prev])  begin bad++; $display("[TB] FAIL reload_scan_an slot=%0d got=%b want=%b", ref_prev, an, exp_an[ref_prev]); end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_load_while_busy();
        test_no_blank();
        test_reset_mid_conv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
